// File: rtl/min_sec_counter_pkg.sv
// Shared constants and the BCD digit type for the mm:ss timekeeping core.
package min_sec_pkg;
    localparam int BCD_W        = 4;
    localparam int SEC_TENS_MAX = 5;
    localparam int DIGIT_MAX    = 9;

    typedef logic [BCD_W-1:0] bcd_digit_t;
endpackage

// File: rtl/min_sec_counter_if.sv
// Tick/run inputs and BCD digit outputs of min_sec_counter; the adjust buttons
// exist only when MIN_SEC_ADJUST_EN is defined.
interface min_sec_counter_if;
    import min_sec_pkg::*;

    // Plain sampled levels, no valid/ready: tick_1hz counts on every cycle it is
    // high while run is high; digits and rollover are registered outputs.
    logic       tick_1hz;
    logic       run;
    bcd_digit_t sec_ones;
    bcd_digit_t sec_tens;
    bcd_digit_t min_ones;
    bcd_digit_t min_tens;
    logic       rollover;
`ifdef MIN_SEC_ADJUST_EN
    logic       inc_sec;
    logic       inc_min;

    modport master (
        output tick_1hz, run, inc_sec, inc_min,
        input  sec_ones, sec_tens, min_ones, min_tens, rollover
    );
    modport slave (
        input  tick_1hz, run, inc_sec, inc_min,
        output sec_ones, sec_tens, min_ones, min_tens, rollover
    );
`else
    modport master (
        output tick_1hz, run,
        input  sec_ones, sec_tens, min_ones, min_tens, rollover
    );
    modport slave (
        input  tick_1hz, run,
        output sec_ones, sec_tens, min_ones, min_tens, rollover
    );
`endif
endinterface

// File: rtl/min_sec_counter_bcd_digit_counter.sv
// One BCD digit: counts 0..WRAP on en_i, clr_i forces 0; carry_o flags the wrap step.
module bcd_digit_counter
    import min_sec_pkg::*;
#(
    parameter int WRAP = DIGIT_MAX
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       clr_i,
    output bcd_digit_t digit_o,
    output logic       carry_o
);
    localparam bcd_digit_t WRAP_VAL = bcd_digit_t'(WRAP);

    bcd_digit_t digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = '0;
        end else if (en_i) begin
            digit_d = (digit_q == WRAP_VAL) ? '0 : digit_q + bcd_digit_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign carry_o = en_i & (digit_q == WRAP_VAL);
    assign digit_o = digit_q;
endmodule

// File: rtl/min_sec_counter.sv
// BCD mm:ss counter advanced by tick_1hz while run is high, wrapping at
// MIN_MODULUS-1:59. Define MIN_SEC_ADJUST_EN for edge-detected inc_sec/inc_min.
module min_sec_counter
    import min_sec_pkg::*;
#(
    parameter int MIN_MODULUS = 60
) (
    input  logic              clk_50mhz,
    input  logic              reset,
    min_sec_counter_if.slave  bus
);
    localparam bcd_digit_t MIN_MAX_TENS = bcd_digit_t'((MIN_MODULUS - 1) / 10);
    localparam bcd_digit_t MIN_MAX_ONES = bcd_digit_t'((MIN_MODULUS - 1) % 10);

    logic       sec_adj, min_adj, adj;
    logic       count_ev, sec_en, min_en, min_max, min_wrap;
    logic       so_carry, st_carry, mo_carry, mt_carry;
    logic       rollover_q, rollover_d;
    bcd_digit_t so_digit, st_digit, mo_digit, mt_digit;

`ifdef MIN_SEC_ADJUST_EN
    logic inc_sec_q, inc_min_q;

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            inc_sec_q <= 1'b0;
            inc_min_q <= 1'b0;
        end else begin
            inc_sec_q <= bus.inc_sec;
            inc_min_q <= bus.inc_min;
        end
    end

    assign sec_adj = bus.inc_sec & ~inc_sec_q;
    assign min_adj = bus.inc_min & ~inc_min_q;
`else
    assign sec_adj = 1'b0;
    assign min_adj = 1'b0;
`endif

    // Any adjust edge swallows a coincident tick; seconds adjust never carries.
    always_comb begin
        adj        = sec_adj | min_adj;
        count_ev   = bus.tick_1hz & bus.run & ~adj;
        sec_en     = count_ev | sec_adj;
        min_en     = (count_ev & st_carry) | min_adj;
        min_max    = (mt_digit == MIN_MAX_TENS) && (mo_digit == MIN_MAX_ONES);
        min_wrap   = (min_en & min_max) | mt_carry;
        rollover_d = count_ev & st_carry & min_max;
    end

    bcd_digit_counter #(.WRAP(DIGIT_MAX)) u_sec_ones (
        .clk_i(clk_50mhz), .rst_i(reset), .en_i(sec_en), .clr_i(1'b0),
        .digit_o(so_digit), .carry_o(so_carry)
    );

    bcd_digit_counter #(.WRAP(SEC_TENS_MAX)) u_sec_tens (
        .clk_i(clk_50mhz), .rst_i(reset), .en_i(so_carry), .clr_i(1'b0),
        .digit_o(st_digit), .carry_o(st_carry)
    );

    bcd_digit_counter #(.WRAP(DIGIT_MAX)) u_min_ones (
        .clk_i(clk_50mhz), .rst_i(reset), .en_i(min_en), .clr_i(min_wrap),
        .digit_o(mo_digit), .carry_o(mo_carry)
    );

    bcd_digit_counter #(.WRAP(DIGIT_MAX)) u_min_tens (
        .clk_i(clk_50mhz), .rst_i(reset), .en_i(mo_carry), .clr_i(min_wrap),
        .digit_o(mt_digit), .carry_o(mt_carry)
    );

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            rollover_q <= 1'b0;
        end else begin
            rollover_q <= rollover_d;
        end
    end

    assign bus.sec_ones = so_digit;
    assign bus.sec_tens = st_digit;
    assign bus.min_ones = mo_digit;
    assign bus.min_tens = mt_digit;
    assign bus.rollover = rollover_q;
endmodule

// File: tb/tb_min_sec_counter.sv
// Directed bench for min_sec_counter: default 60-minute instance plus a MIN_MODULUS=10 one.
module tb_min_sec_counter;
    import min_sec_pkg::*;

    typedef struct {
        int          ticks;
        logic [15:0] exp_digits;
        int          exp_roll;
    } vec_t;

    logic clk_50mhz = 1'b0;
    logic reset     = 1'b1;
    int   total     = 0;
    int   bad       = 0;
    int   roll_cnt  = 0;

    always #10 clk_50mhz = ~clk_50mhz;

    min_sec_counter_if bus ();
    min_sec_counter_if bus10 ();

    min_sec_counter #(.MIN_MODULUS(60)) dut (
        .clk_50mhz(clk_50mhz), .reset(reset), .bus(bus.slave)
    );

    min_sec_counter #(.MIN_MODULUS(10)) dut10 (
        .clk_50mhz(clk_50mhz), .reset(reset), .bus(bus10.slave)
    );

    always @(negedge clk_50mhz) begin
        if (bus.rollover === 1'b1) roll_cnt <= roll_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_50mhz);
            #1;
        end
    endtask

    task automatic set_tick(input logic v);
        bus.tick_1hz   = v;
        bus10.tick_1hz = v;
    endtask

    task automatic set_run(input logic v);
        bus.run   = v;
        bus10.run = v;
    endtask

    task automatic do_reset();
        set_tick(1'b0);
`ifdef MIN_SEC_ADJUST_EN
        bus.inc_sec   = 1'b0;
        bus.inc_min   = 1'b0;
        bus10.inc_sec = 1'b0;
        bus10.inc_min = 1'b0;
`endif
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic hold_ticks(input int n);
        if (n > 0) begin
            set_tick(1'b1);
            step(n);
            set_tick(1'b0);
        end
    endtask

    task automatic pulse_ticks(input int n, input int gap);
        repeat (n) begin
            set_tick(1'b1);
            step(1);
            set_tick(1'b0);
            step(gap);
        end
    endtask

    function automatic logic [15:0] rd();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    function automatic logic [15:0] rd10();
        return {bus10.min_tens, bus10.min_ones, bus10.sec_tens, bus10.sec_ones};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    vec_t vecs[8];
    int   r0;

    initial begin
        vecs[0] = '{9,    16'h0009, 0};
        vecs[1] = '{10,   16'h0010, 0};
        vecs[2] = '{59,   16'h0059, 0};
        vecs[3] = '{60,   16'h0100, 0};
        vecs[4] = '{599,  16'h0959, 0};
        vecs[5] = '{600,  16'h1000, 0};
        vecs[6] = '{3599, 16'h5959, 0};
        vecs[7] = '{3600, 16'h0000, 1};

        set_run(1'b1);
        do_reset();
        check("reset_digits", rd(), 16'h0000);
        check("reset_rollover", {15'b0, bus.rollover}, 16'h0000);

        r0 = roll_cnt;
        pulse_ticks(5, 1000);
        check("five_spaced_ticks", rd(), 16'h0005);
        check("five_ticks_no_roll", 16'(roll_cnt - r0), 16'h0000);

        set_tick(1'b1);
        step(3);
        check("held_tick_counts", rd(), 16'h0008);
        reset = 1'b1;
        step(1);
        check("reset_mid_count", rd(), 16'h0000);
        reset = 1'b0;
        set_tick(1'b0);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            r0 = roll_cnt;
            hold_ticks(vecs[i].ticks);
            check($sformatf("vec%0d_digits", i), rd(), vecs[i].exp_digits);
            step(1);
            check($sformatf("vec%0d_roll", i), 16'(roll_cnt - r0), 16'(vecs[i].exp_roll));
        end

        do_reset();
        hold_ticks(3599);
        check("preload_5959", rd(), 16'h5959);
        r0 = roll_cnt;
        pulse_ticks(1, 0);
        check("wrap_digits", rd(), 16'h0000);
        check("wrap_rollover_high", {15'b0, bus.rollover}, 16'h0001);
        step(1);
        check("wrap_rollover_low", {15'b0, bus.rollover}, 16'h0000);
        check("wrap_roll_once", 16'(roll_cnt - r0), 16'h0001);

        do_reset();
        hold_ticks(599);
        check("mod10_0959", rd10(), 16'h0959);
        pulse_ticks(1, 0);
        check("mod10_wrap", rd10(), 16'h0000);
        check("mod10_rollover", {15'b0, bus10.rollover}, 16'h0001);
        check("mod60_1000", rd(), 16'h1000);
        check("mod60_no_roll", {15'b0, bus.rollover}, 16'h0000);

        do_reset();
        hold_ticks(7);
        set_run(1'b0);
        pulse_ticks(10, 2);
        check("run_low_hold", rd(), 16'h0007);
        set_run(1'b1);
        pulse_ticks(1, 1);
        check("run_resume", rd(), 16'h0008);

        do_reset();
        hold_ticks(3599);
        r0 = roll_cnt;
        set_run(1'b0);
        pulse_ticks(1, 1);
        check("run_low_at_max", rd(), 16'h5959);
        check("run_low_no_roll", 16'(roll_cnt - r0), 16'h0000);
        set_run(1'b1);

`ifdef MIN_SEC_ADJUST_EN
        do_reset();
        hold_ticks(59);
        check("adj_pre_0059", rd(), 16'h0059);
        r0 = roll_cnt;
        bus.inc_sec = 1'b1;
        step(20);
        bus.inc_sec = 1'b0;
        step(1);
        check("adj_sec_wrap", rd(), 16'h0000);
        hold_ticks(330);
        check("adj_pre_0530", rd(), 16'h0530);
        bus.inc_min = 1'b1;
        set_tick(1'b1);
        step(1);
        set_tick(1'b0);
        bus.inc_min = 1'b0;
        step(1);
        check("adj_min_beats_tick", rd(), 16'h0630);
        bus.inc_sec = 1'b1;
        bus.inc_min = 1'b1;
        step(1);
        bus.inc_sec = 1'b0;
        bus.inc_min = 1'b0;
        step(1);
        check("adj_both", rd(), 16'h0731);
        check("adj_no_roll", 16'(roll_cnt - r0), 16'h0000);

        do_reset();
        hold_ticks(3599);
        r0 = roll_cnt;
        bus.inc_sec = 1'b1;
        step(1);
        bus.inc_sec = 1'b0;
        step(1);
        check("adj_sec_at_max", rd(), 16'h5900);
        bus.inc_min = 1'b1;
        step(1);
        bus.inc_min = 1'b0;
        step(1);
        check("adj_min_at_max", rd(), 16'h0000);
        check("adj_max_no_roll", 16'(roll_cnt - r0), 16'h0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
